seg7_scan: RTL and testbench
============================

SEG7_SCAN -- requirements
Module: seg7_scan

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 100000, giving I_CLK cycles per digit slot (legal range 1 to 2^20).
REQ-002 SHALL have parameter BLANK_LZ, default 1, which enables leading-zero blanking when set to 1.
REQ-003 SHALL have port I_CLK, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port I_RST_N, input, 1 bit: synchronous, active-low reset.
REQ-005 SHALL have port I_DATA, input, 32 bits: eight hex nibbles; nibble k = I_DATA[4k+3:4k] drives digit k, with digit 0 the rightmost.
REQ-006 SHALL have port I_LOAD, input, 1 bit: request to capture I_DATA.
REQ-007 SHALL have port I_EN, input, 1 bit: display enable (0 = all digits dark).
REQ-008 SHALL have port I_DP_MASK, input, 8 bits: decimal-point request per digit (1 = lit), sampled live.
REQ-009 SHALL have port O_AN, output, 8 bits: active-low anode select.
REQ-010 SHALL have port O_SEG, output, 7 bits: active-low segments, ordered {g,f,e,d,c,b,a}.
REQ-011 SHALL have port O_DP, output, 1 bit: active-low decimal point.
REQ-012 SHALL have port O_FRAME, output, 1 bit: one-cycle pulse at the end of each frame.

Function
REQ-013 SHALL contain a prescaler that counts 0..SCAN_DIV-1 and wraps to 0; the wrap cycle is the slot tick (with SCAN_DIV=1, every cycle is a tick).
REQ-014 SHALL advance a 3-bit digit index 0..7 on every slot tick, wrapping 7 -> 0; a frame therefore lasts 8*SCAN_DIV cycles.
REQ-015 SHALL register O_AN, O_SEG and O_DP from the current index and display register, so that outputs lag the index by exactly 1 cycle.
REQ-016 SHALL hold a shadow register and a pending flag; when I_LOAD=1 on an edge, the shadow SHALL take I_DATA and pending SHALL be set.
REQ-017 SHALL copy the shadow into the display register only on the frame-boundary tick (index 7 -> 0) while pending=1, then clear pending; the display register SHALL never change mid-frame.
REQ-018 SHALL, when I_LOAD=1 on the frame-boundary tick itself, load I_DATA directly into both the shadow and the display register and leave pending at 0.
REQ-019 SHALL, when I_LOAD is asserted repeatedly within one frame, apply only the last captured value at the next boundary.
REQ-020 SHALL decode hex nibbles to the standard 0-F glyphs, active-low, e.g. 0=1000000, 1=1111001, 8=0000000, A=0001000, F=0001110.
REQ-021 SHALL, when BLANK_LZ=1, blank digit k (k>=1) if nibbles k..7 of the display register are all zero; digit 0 SHALL never be blanked.
REQ-022 SHALL drive a blanked digit slot as O_AN=8'hFF, O_SEG=7'h7F, O_DP=1, regardless of I_DP_MASK.
REQ-023 SHALL drive an unblanked digit slot as O_AN with only bit[index] low, O_SEG = the decoded glyph, and O_DP = ~I_DP_MASK[index].
REQ-024 SHALL, while I_EN=0, drive O_AN=8'hFF, O_SEG=7'h7F, O_DP=1, while the prescaler, index, load path and O_FRAME continue operating.
REQ-025 SHALL pulse O_FRAME high for exactly the 1 cycle following the frame-boundary tick, independent of I_EN.

Reset
REQ-026 SHALL, on any edge with I_RST_N=0, clear the prescaler, index, shadow, display register and pending flag, and set O_AN=8'hFF, O_SEG=7'h7F, O_DP=1, O_FRAME=0.
REQ-027 SHALL ignore I_LOAD while in reset; a reset mid-frame SHALL discard any pending data.
REQ-028 SHALL, on the first edge after release with I_EN=1, present digit 0 showing '0' (O_AN=8'hFE, O_SEG=1000000).

Verification (SCAN_DIV=4, BLANK_LZ=1)
REQ-029 SHALL cover reset release with I_EN=1, I_DP_MASK=0 -> O_AN=FE and O_SEG=1000000 for 4 cycles, then O_AN=FF for slots 1-7, and the first O_FRAME pulse 32 cycles after release.
REQ-030 SHALL cover I_LOAD with 0x12345678 at cycle 10 -> outputs unchanged until O_FRAME; in the next frame, digit 0 shows 0000000 ('8') and digit 7 shows 1111001 ('1').
REQ-031 SHALL cover I_LOAD with 0x0000ABCD on the boundary tick -> the immediately following frame shows D,C,B,A on digits 0-3, with digits 4-7 blanked.
REQ-032 SHALL cover I_EN=0 for 2 frames -> O_AN=FF, O_SEG=7F, O_DP=1 throughout, and O_FRAME still pulsing every 32 cycles.
REQ-033 SHALL cover display 0x00000000 with I_DP_MASK=0x03 -> O_DP=0 only in the digit 0 slot, since digit 1 is blanked.
REQ-034 SHALL cover I_RST_N=0 for 1 cycle mid-frame with a load pending -> all outputs at reset values on the next edge, and digit 0 showing '0' after release.

Source files
------------

// File: rtl/seg7_scan.sv
// Multiplexed eight-digit seven-segment driver with frame-synchronous display
// updates and optional leading-zero blanking.
module seg7_scan #(
  parameter int SCAN_DIV = 100000,
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic        I_CLK,
  input  logic        I_RST_N,
  input  logic [31:0] I_DATA,
  input  logic        I_LOAD,
  input  logic        I_EN,
  input  logic [7:0]  I_DP_MASK,
  output logic [7:0]  O_AN,
  output logic [6:0]  O_SEG,
  output logic        O_DP,
  output logic        O_FRAME
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] DIV_LAST = CW'(SCAN_DIV - 1);

  logic [CW-1:0] presc_reg;
  logic [2:0]    idx_reg;
  logic [31:0]   shadow_reg;
  logic [31:0]   disp_reg;
  logic          pending_reg;

  logic          tick;
  logic          boundary;
  logic [7:0]    lz;
  logic [3:0]    nibble;
  logic [6:0]    glyph;
  logic          blank;

  assign tick     = (presc_reg == DIV_LAST);
  assign boundary = tick && (idx_reg == 3'd7);

  // lz[k] is set when nibbles k..7 of the displayed value are all zero
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_lz
      assign lz[gi] = (disp_reg[31:4*gi] == '0);
    end
  endgenerate

  assign nibble = disp_reg[{idx_reg, 2'b00} +: 4];
  assign blank  = BLANK_LZ && (idx_reg != 3'd0) && lz[idx_reg];

  always_comb begin
    glyph = 7'h7F;
    case (nibble)
      4'h0: glyph = 7'b1000000;
      4'h1: glyph = 7'b1111001;
      4'h2: glyph = 7'b0100100;
      4'h3: glyph = 7'b0110000;
      4'h4: glyph = 7'b0011001;
      4'h5: glyph = 7'b0010010;
      4'h6: glyph = 7'b0000010;
      4'h7: glyph = 7'b1111000;
      4'h8: glyph = 7'b0000000;
      4'h9: glyph = 7'b0010000;
      4'hA: glyph = 7'b0001000;
      4'hB: glyph = 7'b0000011;
      4'hC: glyph = 7'b1000110;
      4'hD: glyph = 7'b0100001;
      4'hE: glyph = 7'b0000110;
      4'hF: glyph = 7'b0001110;
      default: glyph = 7'h7F;
    endcase
  end

  always_ff @(posedge I_CLK) begin
    if (!I_RST_N) begin
      presc_reg   <= '0;
      idx_reg     <= 3'd0;
      shadow_reg  <= '0;
      disp_reg    <= '0;
      pending_reg <= 1'b0;
      O_AN        <= 8'hFF;
      O_SEG       <= 7'h7F;
      O_DP        <= 1'b1;
      O_FRAME     <= 1'b0;
    end else begin
      presc_reg <= tick ? '0 : presc_reg + 1'b1;
      if (tick)
        idx_reg <= idx_reg + 3'd1;

      // A load on the boundary itself bypasses the shadow so it shows at once
      if (I_LOAD) begin
        shadow_reg <= I_DATA;
        if (boundary) begin
          disp_reg    <= I_DATA;
          pending_reg <= 1'b0;
        end else begin
          pending_reg <= 1'b1;
        end
      end else if (boundary && pending_reg) begin
        disp_reg    <= shadow_reg;
        pending_reg <= 1'b0;
      end

      O_FRAME <= boundary;

      if (!I_EN || blank) begin
        O_AN  <= 8'hFF;
        O_SEG <= 7'h7F;
        O_DP  <= 1'b1;
      end else begin
        O_AN  <= ~(8'd1 << idx_reg);
        O_SEG <= glyph;
        O_DP  <= ~I_DP_MASK[idx_reg];
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan.sv
// Bench for seg7_scan: cycle-count reference model checked every cycle, plus
// directed literal checks on the scenarios of interest.
module tb_seg7_scan;

  localparam int DIV   = 4;
  localparam int FRAME = 8 * DIV;

  logic        clk;
  logic        rst_n;
  logic [31:0] data;
  logic        load;
  logic        en;
  logic [7:0]  dp_mask;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame;

  int checks   = 0;
  int failures = 0;
  int n_tb     = 0;

  seg7_scan #(.SCAN_DIV(DIV), .BLANK_LZ(1'b1)) dut (
    .I_CLK(clk),
    .I_RST_N(rst_n),
    .I_DATA(data),
    .I_LOAD(load),
    .I_EN(en),
    .I_DP_MASK(dp_mask),
    .O_AN(an),
    .O_SEG(seg),
    .O_DP(dp),
    .O_FRAME(frame)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [6:0] glyph_tab [16];
  initial begin
    glyph_tab[0]  = 7'b1000000; glyph_tab[1]  = 7'b1111001;
    glyph_tab[2]  = 7'b0100100; glyph_tab[3]  = 7'b0110000;
    glyph_tab[4]  = 7'b0011001; glyph_tab[5]  = 7'b0010010;
    glyph_tab[6]  = 7'b0000010; glyph_tab[7]  = 7'b1111000;
    glyph_tab[8]  = 7'b0000000; glyph_tab[9]  = 7'b0010000;
    glyph_tab[10] = 7'b0001000; glyph_tab[11] = 7'b0000011;
    glyph_tab[12] = 7'b1000110; glyph_tab[13] = 7'b0100001;
    glyph_tab[14] = 7'b0000110; glyph_tab[15] = 7'b0001110;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Time is counted in edges since reset release; slot and frame follow from
  // that count directly.
  int          m_n = 0;
  logic [31:0] m_disp = '0, m_shadow = '0;
  bit          m_pend = 0;
  logic [7:0]  e_an;
  logic [6:0]  e_seg;
  logic        e_dp, e_fr;

  always begin
    int slot, hi;
    bit bnd;
    logic s_rst, s_load, s_en;
    logic [31:0] s_data;
    logic [7:0] s_dp;
    @(posedge clk);
    s_rst = rst_n; s_load = load; s_data = data; s_en = en; s_dp = dp_mask;
    if (!s_rst) begin
      m_n = 0; m_disp = '0; m_shadow = '0; m_pend = 0;
      e_an = 8'hFF; e_seg = 7'h7F; e_dp = 1'b1; e_fr = 1'b0;
    end else begin
      m_n++;
      slot = ((m_n - 1) / DIV) % 8;
      bnd  = (m_n % FRAME) == 0;
      hi = 0;
      for (int k = 0; k < 8; k++)
        if (((m_disp >> (4 * k)) & 32'hF) != 0) hi = k;
      if (!s_en || slot > hi) begin
        e_an = 8'hFF; e_seg = 7'h7F; e_dp = 1'b1;
      end else begin
        e_an  = ~(8'(1) << slot);
        e_seg = glyph_tab[(m_disp >> (4 * slot)) & 32'hF];
        e_dp  = ~s_dp[slot];
      end
      e_fr = bnd;
      if (s_load) begin
        $display("load edge=%0d data=%h boundary=%0d", m_n, s_data, bnd);
        m_shadow = s_data;
        if (bnd) begin m_disp = s_data; m_pend = 0; end
        else m_pend = 1;
      end else if (bnd && m_pend) begin
        m_disp = m_shadow; m_pend = 0;
      end
    end
    #1;
    check("model_an", {24'h0, an}, {24'h0, e_an});
    check("model_seg", {25'h0, seg}, {25'h0, e_seg});
    check("model_dp", {31'h0, dp}, {31'h0, e_dp});
    check("model_frame", {31'h0, frame}, {31'h0, e_fr});
  end

  // ---------------- stimulus ----------------
  task automatic goto_edge(input int k);
    while (n_tb < k) begin
      @(negedge clk);
      n_tb++;
    end
  endtask

  initial begin
    rst_n = 1'b0; data = '0; load = 1'b0; en = 1'b1; dp_mask = 8'h00;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    n_tb = 0;

    $display("phase: reset release");
    goto_edge(1);
    check("rel_an", {24'h0, an}, 32'hFE);
    check("rel_seg", {25'h0, seg}, 32'h40);
    goto_edge(4);
    check("rel_an_slot0_end", {24'h0, an}, 32'hFE);
    goto_edge(5);
    check("rel_an_slot1", {24'h0, an}, 32'hFF);

    $display("phase: mid-frame load 12345678");
    goto_edge(9);  load = 1'b1; data = 32'h12345678;
    goto_edge(10); load = 1'b0;
    check("hold_an", {24'h0, an}, 32'hFF);
    goto_edge(31);
    check("no_early_frame", {31'h0, frame}, 32'h0);
    goto_edge(32);
    check("first_frame", {31'h0, frame}, 32'h1);
    goto_edge(33);
    check("d0_is_8_an", {24'h0, an}, 32'hFE);
    check("d0_is_8_seg", {25'h0, seg}, 32'h00);
    goto_edge(61);
    check("d7_an", {24'h0, an}, 32'h7F);
    check("d7_is_1_seg", {25'h0, seg}, 32'h79);

    $display("phase: boundary load 0000ABCD");
    goto_edge(63); load = 1'b1; data = 32'h0000ABCD;
    goto_edge(64); load = 1'b0;
    goto_edge(65);
    check("abcd_d0_seg", {25'h0, seg}, 32'h21);
    goto_edge(69);
    check("abcd_d1_seg", {25'h0, seg}, 32'h46);
    goto_edge(81);
    check("abcd_d4_blank", {24'h0, an}, 32'hFF);

    $display("phase: display disabled");
    goto_edge(90); en = 1'b0;
    goto_edge(93);
    check("dis_seg", {25'h0, seg}, 32'h7F);
    goto_edge(96);
    check("dis_frame1", {31'h0, frame}, 32'h1);
    goto_edge(128);
    check("dis_frame2", {31'h0, frame}, 32'h1);

    $display("phase: zero display with dp mask 03");
    goto_edge(154); en = 1'b1; load = 1'b1; data = 32'h0; dp_mask = 8'h03;
    goto_edge(155); load = 1'b0;
    goto_edge(161);
    check("dp_d0_lit", {31'h0, dp}, 32'h0);
    goto_edge(165);
    check("dp_d1_blank", {31'h0, dp}, 32'h1);

    $display("phase: reset mid-frame with pending load");
    goto_edge(170); load = 1'b1; data = 32'hFFFFFFFF;
    goto_edge(171); load = 1'b0;
    goto_edge(175); rst_n = 1'b0;
    goto_edge(176); rst_n = 1'b1;
    check("rst_an", {24'h0, an}, 32'hFF);
    check("rst_seg", {25'h0, seg}, 32'h7F);
    goto_edge(177);
    check("rst_rel_seg", {25'h0, seg}, 32'h40);
    goto_edge(208);
    check("rst_frame", {31'h0, frame}, 32'h1);
    goto_edge(209);
    check("pending_dropped", {25'h0, seg}, 32'h40);

    $display("phase: random");
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      rst_n   = ($urandom_range(0, 499) != 0);
      load    = ($urandom_range(0, 15) == 0);
      data    = $urandom >> (4 * $urandom_range(0, 7));
      en      = ($urandom_range(0, 9) != 0);
      dp_mask = 8'($urandom);
    end
    @(negedge clk);
    #2;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
